// File: rtl/wm8731_pkg.sv
// wm8731_pkg: sequencer state type, WM8731 register map and the
// power-up register table written after reset.
package wm8731_pkg;

  typedef enum logic [2:0] {
    S_POR_WAIT,
    S_LOAD,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [6:0] R0_LLINE_IN     = 7'h00;
  localparam logic [6:0] R1_RLINE_IN     = 7'h01;
  localparam logic [6:0] R2_LHP_OUT      = 7'h02;
  localparam logic [6:0] R3_RHP_OUT      = 7'h03;
  localparam logic [6:0] R4_ANALOG_PATH  = 7'h04;
  localparam logic [6:0] R5_DIGITAL_PATH = 7'h05;
  localparam logic [6:0] R6_POWER_DOWN   = 7'h06;
  localparam logic [6:0] R7_DIGITAL_IF   = 7'h07;
  localparam logic [6:0] R8_SAMPLING     = 7'h08;
  localparam logic [6:0] R9_ACTIVE       = 7'h09;
  localparam logic [6:0] R15_RESET       = 7'h0F;

  localparam int SEQ_LEN_C = 8;

  function automatic logic [15:0] pack_word(
    input logic [6:0] addr,
    input logic [8:0] data
  );
    return {addr, data};
  endfunction

  // HP volume write uses the both-channel update bit (data[8])
  localparam logic [15:0] INIT_TABLE [SEQ_LEN_C] = '{
    pack_word(R15_RESET,       9'h000),
    pack_word(R6_POWER_DOWN,   9'h000),
    pack_word(R4_ANALOG_PATH,  9'h012),
    pack_word(R5_DIGITAL_PATH, 9'h000),
    pack_word(R7_DIGITAL_IF,   9'h002),
    pack_word(R8_SAMPLING,     9'h000),
    pack_word(R2_LHP_OUT,      9'h17B),
    pack_word(R9_ACTIVE,       9'h001)
  };

endpackage

// File: rtl/wm8731_init_rom.sv
// wm8731_init_rom: combinational lookup of one init table word.
module wm8731_init_rom
  import wm8731_pkg::*;
(
  input  logic [2:0]  idx_i,
  output logic [15:0] word_o
);

  assign word_o = INIT_TABLE[idx_i];

endmodule

// File: rtl/wm8731_config_sequencer.sv
// wm8731_config_sequencer: writes the WM8731 init table through the I2C
// driver port with retries, then serves runtime single-register writes.
module wm8731_config_sequencer
  import wm8731_pkg::*;
#(
  parameter int SEQ_LEN     = SEQ_LEN_C,
  parameter int POR_DELAY   = 50000,
  parameter int GAP_CYCLES  = 5000,
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRIES = 3
) (
  input  logic        CLOCK50M,
  input  logic        RESET_N,
  input  logic        restart,
  input  logic        drv_busy,
  input  logic        drv_done,
  input  logic        drv_nack,
  output logic        InitialiseTransfer,
  output logic [15:0] message,
  input  logic        rt_req,
  input  logic [15:0] rt_word,
  output logic        rt_ack,
  output logic        rt_fail,
  output logic        config_done,
  output logic        config_error,
  output logic [2:0]  seq_index
);

  localparam int CMAX_PG = (POR_DELAY > GAP_CYCLES) ? POR_DELAY : GAP_CYCLES;
  localparam int CMAX    = (CMAX_PG > ACK_TIMEOUT) ? CMAX_PG : ACK_TIMEOUT;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] POR_END   = CW'(POR_DELAY - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_END   = CW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [2:0]    LAST_IDX  = 3'(SEQ_LEN - 1);

  state_e        state_q;
  state_e        gap_nxt_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] retry_q;
  logic [2:0]    idx_q;
  logic          src_rt_q;
  logic [15:0]   rt_word_q;
  logic [15:0]   msg_q;
  logic          launch_q;
  logic          rt_ack_q;
  logic          rt_fail_q;
  logic          done_q;
  logic          err_q;
  logic [15:0]   rom_word;
  logic          xfer_ok;
  logic          xfer_fail;

  wm8731_init_rom u_rom (
    .idx_i  (idx_q),
    .word_o (rom_word)
  );

  // a done seen in WAIT_BUSY comes from a driver fast enough to skip busy
  always_comb begin
    xfer_ok   = 1'b0;
    xfer_fail = 1'b0;
    if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
      if (drv_done) begin
        xfer_ok   = !drv_nack;
        xfer_fail = drv_nack;
      end else if (state_q == S_WAIT_BUSY && !drv_busy && cnt_q == TMO_END) begin
        xfer_fail = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_POR_WAIT;
      gap_nxt_q <= S_LOAD;
      cnt_q     <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      src_rt_q  <= 1'b0;
      rt_word_q <= '0;
      msg_q     <= '0;
      launch_q  <= 1'b0;
      rt_ack_q  <= 1'b0;
      rt_fail_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      launch_q  <= 1'b0;
      rt_ack_q  <= 1'b0;
      rt_fail_q <= 1'b0;
      if (xfer_fail) begin
        cnt_q <= '0;
        if (retry_q < RETRY_MAX) begin
          retry_q   <= retry_q + 1'b1;
          gap_nxt_q <= S_LAUNCH;
          state_q   <= S_GAP;
        end else begin
          retry_q <= '0;
          if (src_rt_q) begin
            rt_ack_q  <= 1'b1;
            rt_fail_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end
        end
      end else if (xfer_ok) begin
        cnt_q   <= '0;
        retry_q <= '0;
        state_q <= S_GAP;
        if (src_rt_q) begin
          rt_ack_q  <= 1'b1;
          gap_nxt_q <= S_DONE;
        end else if (idx_q == LAST_IDX) begin
          gap_nxt_q <= S_DONE;
        end else begin
          idx_q     <= idx_q + 3'd1;
          gap_nxt_q <= S_LOAD;
        end
      end else begin
        unique case (state_q)
          S_POR_WAIT: begin
            if (cnt_q == POR_END) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_LOAD: begin
            msg_q   <= src_rt_q ? rt_word_q : rom_word;
            state_q <= S_LAUNCH;
          end
          S_LAUNCH: begin
            launch_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (drv_busy) state_q <= S_WAIT_DONE;
            else          cnt_q   <= cnt_q + 1'b1;
          end
          S_WAIT_DONE: begin
          end
          S_GAP: begin
            if (cnt_q == GAP_END) begin
              cnt_q   <= '0;
              state_q <= gap_nxt_q;
              if (gap_nxt_q == S_DONE && !src_rt_q) done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DONE, S_ERROR: begin
            if (restart) begin
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              idx_q    <= '0;
              retry_q  <= '0;
              src_rt_q <= 1'b0;
              state_q  <= S_LOAD;
            end else if (state_q == S_DONE && rt_req) begin
              rt_word_q <= rt_word;
              src_rt_q  <= 1'b1;
              state_q   <= S_LOAD;
            end
          end
          default: state_q <= S_POR_WAIT;
        endcase
      end
    end
  end

  assign InitialiseTransfer = launch_q;
  assign message            = msg_q;
  assign rt_ack             = rt_ack_q;
  assign rt_fail            = rt_fail_q;
  assign config_done        = done_q;
  assign config_error       = err_q;
  assign seq_index          = idx_q;

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// tb_wm8731_config_sequencer: driver model, launch/ack scoreboard and
// randomized NACK/timeout plans against a retry-count reference model.
module tb_wm8731_config_sequencer;

  localparam int POR     = 200;
  localparam int GAP     = 40;
  localparam int TMO     = 32;
  localparam int RETRIES = 3;
  localparam int BOUND   = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        drv_busy = 1'b0;
  logic        drv_done = 1'b0;
  logic        drv_nack = 1'b0;
  logic        rt_req = 1'b0;
  logic [15:0] rt_word = 16'h0;
  logic        init_tx;
  logic [15:0] message;
  logic        rt_ack;
  logic        rt_fail;
  logic        cfg_done;
  logic        cfg_err;
  logic [2:0]  seq_index;

  always #10 clk = ~clk;

  wm8731_config_sequencer #(
    .POR_DELAY   (POR),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (TMO),
    .MAX_RETRIES (RETRIES)
  ) dut (
    .CLOCK50M           (clk),
    .RESET_N            (rst_n),
    .restart            (restart),
    .drv_busy           (drv_busy),
    .drv_done           (drv_done),
    .drv_nack           (drv_nack),
    .InitialiseTransfer (init_tx),
    .message            (message),
    .rt_req             (rt_req),
    .rt_word            (rt_word),
    .rt_ack             (rt_ack),
    .rt_fail            (rt_fail),
    .config_done        (cfg_done),
    .config_error       (cfg_err),
    .seq_index          (seq_index)
  );

  logic [15:0] table_w [8] = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00,
                               16'h0E02, 16'h1000, 16'h057B, 16'h1201};

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  bit          ack_q [$];
  int          nack_map [logic [15:0]];
  int          drop_map [logic [15:0]];
  int          cyc = 0;
  int          rel_cyc = 0;
  int          last_launch = 0;
  int          last_done = 0;
  bit          first_launch = 1'b1;
  bit          skip_gap = 1'b0;
  bit          prev_init = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_checks++;
    if (act < lim) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lim);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // driver model: busy one cycle after launch, done 2..6 cycles later
  initial begin : drv_model
    int left;
    bit nack_now;
    bit nb;
    bit nd;
    bit nn;
    left = 0;
    nack_now = 1'b0;
    forever begin
      @(negedge clk);
      nb = drv_busy;
      nd = 1'b0;
      nn = 1'b0;
      if (drv_busy) begin
        left--;
        if (left <= 0) begin
          nb = 1'b0;
          nd = 1'b1;
          nn = nack_now;
        end
      end else if (init_tx && rst_n) begin
        if (drop_map.exists(message) && drop_map[message] > 0) begin
          drop_map[message]--;
        end else begin
          nb = 1'b1;
          left = $urandom_range(2, 6);
          nack_now = nack_map.exists(message) && nack_map[message] > 0;
          if (nack_now) nack_map[message]--;
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        drv_busy = 1'b0;
        drv_done = 1'b0;
        drv_nack = 1'b0;
        left = 0;
      end else begin
        drv_busy = nb;
        drv_done = nd;
        drv_nack = nn;
      end
    end
  end

  // monitor: pops expected launches and acks as the DUT presents them
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rel_cyc = cyc;
        first_launch = 1'b1;
        prev_init = 1'b0;
      end else begin
        if (init_tx) begin
          check_eq("launch_pulse_width", 32'(prev_init), 32'd0);
          if (exp_q.size() == 0) fail_now("unexpected_launch", 32'(message));
          else check_eq("launch_message", 32'(message), 32'(exp_q.pop_front()));
          if (first_launch) check_ge("por_delay", cyc - rel_cyc, POR);
          else if (!skip_gap) begin
            if (last_done > last_launch)
              check_ge("gap_after_done", cyc - last_done, GAP);
            else
              check_ge("gap_after_timeout", cyc - last_launch, TMO + GAP);
          end
          first_launch = 1'b0;
          skip_gap = 1'b0;
          last_launch = cyc;
        end
        prev_init = init_tx;
        if (drv_done) last_done = cyc;
        if (rt_ack) begin
          if (ack_q.size() == 0) fail_now("unexpected_rt_ack", 32'(rt_fail));
          else check_eq("rt_fail", 32'(rt_fail), 32'(ack_q.pop_front()));
        end
      end
    end
  end

  // every stimulus wait goes through here so the requester drops on ack
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rt_ack) rt_req = 1'b0;
    end
  endtask

  task automatic plan_init(input int nk [8], input int dr [8],
                           output bit exp_err, output int exp_idx);
    nack_map.delete();
    drop_map.delete();
    exp_err = 1'b0;
    exp_idx = 7;
    for (int e = 0; e < 8; e++) begin
      int f;
      int tries;
      f = nk[e] + dr[e];
      tries = (f > RETRIES) ? RETRIES + 1 : f + 1;
      nack_map[table_w[e]] = nk[e];
      drop_map[table_w[e]] = dr[e];
      for (int k = 0; k < tries; k++) exp_q.push_back(table_w[e]);
      if (f > RETRIES) begin
        exp_err = 1'b1;
        exp_idx = e;
        break;
      end
    end
  endtask

  task automatic wait_cfg(input string tag, input bit exp_err, input int exp_idx);
    int n;
    n = 0;
    while (!(cfg_done || cfg_err) && n < BOUND) begin
      tick(1);
      n++;
    end
    if (n >= BOUND) fail_now({tag, "_cfg_timeout"}, 32'(n));
    check_eq({tag, "_config_done"}, 32'(cfg_done), 32'(!exp_err));
    check_eq({tag, "_config_error"}, 32'(cfg_err), 32'(exp_err));
    check_eq({tag, "_seq_index"}, 32'(seq_index), 32'(exp_idx));
    tick(3 * GAP);
    check_eq({tag, "_pending_launches"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    skip_gap = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(1);
    check_eq("restart_clears_done", 32'(cfg_done), 32'd0);
    check_eq("restart_clears_error", 32'(cfg_err), 32'd0);
  endtask

  task automatic rt_write(input logic [15:0] w, input int nk);
    int tries;
    int n;
    tries = (nk > RETRIES) ? RETRIES + 1 : nk + 1;
    n = 0;
    nack_map.delete();
    drop_map.delete();
    nack_map[w] = nk;
    repeat (tries) exp_q.push_back(w);
    ack_q.push_back(nk > RETRIES);
    rt_word = w;
    rt_req = 1'b1;
    tick(1);
    rt_word = 16'($urandom());
    while (rt_req && n < BOUND) begin
      tick(1);
      n++;
    end
    if (rt_req) begin
      fail_now("rt_ack_timeout", 32'(n));
      rt_req = 1'b0;
    end
    tick(GAP + 5);
    check_eq("rt_pending_launches", 32'(exp_q.size()), 32'd0);
    check_eq("rt_config_done_held", 32'(cfg_done), 32'd1);
  endtask

  function automatic logic [15:0] rand_rt_word();
    return {7'd3, 9'($urandom())};
  endfunction

  initial begin : stim
    int          nk [8];
    int          dr [8];
    bit          e_err;
    int          e_idx;
    logic [15:0] w;
    int          n;

    tick(5);
    check_eq("reset_launch", 32'(init_tx), 32'd0);
    check_eq("reset_message", 32'(message), 32'd0);
    check_eq("reset_flags", {28'd0, cfg_done, cfg_err, rt_ack, rt_fail}, 32'd0);
    check_eq("reset_seq_index", 32'(seq_index), 32'd0);

    // clean sequence; runtime request raised mid-init must wait
    nk = '{default: 0};
    dr = '{default: 0};
    plan_init(nk, dr, e_err, e_idx);
    w = rand_rt_word();
    exp_q.push_back(w);
    ack_q.push_back(1'b0);
    rst_n = 1'b1;
    tick(POR + 100);
    rt_word = w;
    rt_req = 1'b1;
    wait_cfg("t1", e_err, e_idx);
    tick(2 * GAP);
    check_eq("t1_rt_ack_seen", 32'(ack_q.size()), 32'd0);

    rt_write(16'h057F, 0);

    // entry 3 NACKed twice; restart and rt_req together, restart wins
    nk = '{default: 0};
    nk[3] = 2;
    plan_init(nk, dr, e_err, e_idx);
    w = rand_rt_word();
    exp_q.push_back(w);
    ack_q.push_back(1'b0);
    rt_word = w;
    rt_req = 1'b1;
    do_restart();
    wait_cfg("t2", e_err, e_idx);
    tick(2 * GAP);
    check_eq("t2_rt_ack_seen", 32'(ack_q.size()), 32'd0);

    // entry 2 NACKed four times: ERROR, runtime requests ignored
    nk = '{default: 0};
    nk[2] = 4;
    plan_init(nk, dr, e_err, e_idx);
    do_restart();
    wait_cfg("t3", e_err, e_idx);
    rt_word = rand_rt_word();
    rt_req = 1'b1;
    tick(4 * GAP);
    rt_req = 1'b0;
    check_eq("t3_error_held", 32'(cfg_err), 32'd1);
    nk = '{default: 0};
    plan_init(nk, dr, e_err, e_idx);
    do_restart();
    wait_cfg("t3b", e_err, e_idx);

    // busy never rises for entry 0
    dr = '{default: 0};
    dr[0] = 4;
    plan_init(nk, dr, e_err, e_idx);
    do_restart();
    wait_cfg("t4", e_err, e_idx);
    dr = '{default: 0};
    plan_init(nk, dr, e_err, e_idx);
    do_restart();
    wait_cfg("t4b", e_err, e_idx);

    rt_write(rand_rt_word(), 4);
    rt_write(rand_rt_word(), $urandom_range(1, 3));

    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 8; e++) begin
        nk[e] = ($urandom_range(0, 11) == 0) ? 4 : $urandom_range(0, 2);
        dr[e] = ($urandom_range(0, 9) == 0) ? 1 : 0;
      end
      plan_init(nk, dr, e_err, e_idx);
      do_restart();
      wait_cfg("rand", e_err, e_idx);
    end

    // reset while the third write is in flight
    nk = '{default: 0};
    dr = '{default: 0};
    plan_init(nk, dr, e_err, e_idx);
    do_restart();
    n = 0;
    while (!(drv_busy && exp_q.size() == 5) && n < BOUND) begin
      tick(1);
      n++;
    end
    if (n >= BOUND) fail_now("t6_busy_timeout", 32'(n));
    rst_n = 1'b0;
    #1;
    check_eq("t6_reset_message", 32'(message), 32'd0);
    check_eq("t6_reset_outputs",
             {25'd0, init_tx, cfg_done, cfg_err, rt_ack, rt_fail, seq_index == 3'd0},
             32'd1);
    exp_q.delete();
    ack_q.delete();
    tick(5);
    plan_init(nk, dr, e_err, e_idx);
    rst_n = 1'b1;
    wait_cfg("t6", e_err, e_idx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
